pg_addacc: RTL

PG_ADDACC -- requirements
Module: pg_addacc

---
 rtl/pg_pkg.sv | 23 ++
 rtl/pg_addacc_tt.sv | 39 +++
 rtl/pg_alu.sv | 62 ++++++
 rtl/pg_addacc.sv | 103 ++++++++++
 4 files changed

// File: rtl/pg_pkg.sv
// pg_pkg -- shared mode encodings and helpers for the pg_addacc block.
// Rev 1.0
`default_nettype none

package pg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // True for the modes whose result is written back into the accumulator.
  function automatic logic writes_acc(input mode_e m);
    return (m == MODE_ACC) || (m == MODE_LOAD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pg_addacc_tt.sv
// pg_addacc_tt -- pin-level wrapper: ui_in/uio_in carry the operands, rst_n
// is the active-low board reset. Rev 1.0
`default_nettype none

module pg_addacc_tt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  input  logic [3:0]  ctrl_in,
  output logic [7:0]  uo_out,
  output logic [3:0]  status_out,
  output logic [15:0] count_out
);

  // ctrl_in = {out_ready, in_valid, mode[1:0]}; status_out = {in_ready, out_valid, carry, ovf}
  pg_addacc #(
    .WIDTH (8),
    .SAT   (0),
    .CNTW  (16)
  ) u_core (
    .clk       (clk),
    .rst       (!rst_n),
    .in_valid  (ctrl_in[2]),
    .in_ready  (status_out[3]),
    .a         (ui_in),
    .b         (uio_in),
    .mode      (ctrl_in[1:0]),
    .out_valid (status_out[2]),
    .out_ready (ctrl_in[3]),
    .result    (uo_out),
    .carry     (status_out[1]),
    .ovf       (status_out[0]),
    .op_count  (count_out)
  );

endmodule

`default_nettype wire

// File: rtl/pg_alu.sv
// pg_alu -- combinational add/sub/accumulate/load with wrap or saturate.
// Rev 1.0
`default_nettype none

module pg_alu
  import pg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0]  op_a_i,
  input  logic [WIDTH-1:0]  op_b_i,
  input  logic [WIDTH-1:0]  acc_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              carry_o,
  output logic              ovf_o
);

  mode_e            w_mode;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_clip;

  assign w_mode = mode_e'(mode_i);

  // ACC reuses the adder with the accumulator as the left operand.
  assign w_sum  = (w_mode == MODE_ACC) ? ({1'b0, acc_i} + {1'b0, op_a_i})
                                       : ({1'b0, op_a_i} + {1'b0, op_b_i});
  assign w_diff = {1'b0, op_a_i} - {1'b0, op_b_i};

  always_comb begin
    w_raw   = op_a_i;
    w_clip  = '0;
    carry_o = 1'b0;
    unique case (w_mode)
      MODE_ADD, MODE_ACC: begin
        w_raw   = w_sum[WIDTH-1:0];
        w_clip  = '1;
        carry_o = w_sum[WIDTH];
      end
      MODE_SUB: begin
        w_raw   = w_diff[WIDTH-1:0];
        w_clip  = '0;
        carry_o = w_diff[WIDTH];
      end
      MODE_LOAD: begin
        w_raw   = op_a_i;
        w_clip  = op_a_i;
        carry_o = 1'b0;
      end
    endcase
  end

  // Whenever the unclipped operation carries or borrows, saturation clips it.
  assign result_o = ((SAT != 0) && carry_o) ? w_clip : w_raw;
  assign ovf_o    = carry_o;

endmodule

`default_nettype wire

// File: rtl/pg_addacc.sv
// pg_addacc -- handshaked ALU with one-entry output register, accumulator
// and accepted-beat counter. Rev 1.0
`default_nettype none

module pg_addacc
  import pg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SAT   = 0,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic [CNTW-1:0]  op_count
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             w_accept;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_carry;
  logic             w_alu_ovf;

  pg_alu #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_alu (
    .op_a_i   (a),
    .op_b_i   (b),
    .acc_i    (acc_q),
    .mode_i   (mode),
    .result_o (w_alu_result),
    .carry_o  (w_alu_carry),
    .ovf_o    (w_alu_ovf)
  );

  // Register may refill in the same cycle it drains, so flow never bubbles.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      result_d    = w_alu_result;
      carry_d     = w_alu_carry;
      ovf_d       = w_alu_ovf;
      cnt_d       = cnt_q + CNTW'(1);
      if (writes_acc(mode_e'(mode))) begin
        acc_d = w_alu_result;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign op_count  = cnt_q;

endmodule

`default_nettype wire
